// File: rtl/mux_masters_pkg.sv
// mux_masters_pkg: shared command encodings, master select type and default bus widths.
package mux_masters_pkg;
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef enum logic {SEL_M1, SEL_M2} master_sel_e;
endpackage

// File: rtl/mux_masters.sv
// mux_masters: two-master to one-slave req/ack mux with a transaction lock.
// MUX_MASTERS_RDATA_GATE_EN zeroes rdata toward the non-selected master; otherwise rdata is broadcast.
module mux_masters
  import mux_masters_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        arb_master_req,
  input  logic              master_1_req,
  input  logic [ADDR_W-1:0] master_1_addr,
  input  logic              master_1_cmd,
  input  logic [DATA_W-1:0] master_1_wdata,
  input  logic              master_2_req,
  input  logic [ADDR_W-1:0] master_2_addr,
  input  logic              master_2_cmd,
  input  logic [DATA_W-1:0] master_2_wdata,
  input  logic              slave_ack,
  input  logic [DATA_W-1:0] slave_rdata,
  output logic              master_1_ack,
  output logic [DATA_W-1:0] master_1_rdata,
  output logic              master_2_ack,
  output logic [DATA_W-1:0] master_2_rdata,
  output logic              slave_req,
  output logic [ADDR_W-1:0] slave_addr,
  output logic              slave_cmd,
  output logic [DATA_W-1:0] slave_wdata
);
  logic busy, m1, m2;
  master_sel_e owner, sel;
  // Lock only while a request waits for its ack; a same-cycle ack never locks.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy  <= 1'b0;
      owner <= SEL_M1;
    end else if (slave_ack) begin
      busy <= 1'b0;
    end else if (slave_req) begin
      busy  <= 1'b1;
      owner <= sel;
    end
  always_comb begin
    sel = busy ? owner : (arb_master_req[0] ? SEL_M1 : SEL_M2);
    m1  = (busy | (|arb_master_req)) & (sel == SEL_M1);
    m2  = (busy | (|arb_master_req)) & (sel == SEL_M2);
    slave_req    = rst_n & ((m1 & master_1_req) | (m2 & master_2_req));
    slave_addr   = m1 ? master_1_addr  : m2 ? master_2_addr  : '0;
    slave_cmd    = m1 ? master_1_cmd   : m2 ? master_2_cmd   : CMD_READ;
    slave_wdata  = m1 ? master_1_wdata : m2 ? master_2_wdata : '0;
    master_1_ack = rst_n & m1 & slave_ack;
    master_2_ack = rst_n & m2 & slave_ack;
`ifdef MUX_MASTERS_RDATA_GATE_EN
    master_1_rdata = m1 ? slave_rdata : '0;
    master_2_rdata = m2 ? slave_rdata : '0;
`else
    master_1_rdata = slave_rdata;
    master_2_rdata = slave_rdata;
`endif
  end
endmodule

// File: tb/tb_mux_masters.sv
// tb_mux_masters: scoreboard bench with a transaction-level reference model of the mux.
module tb_mux_masters;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  grant;
  logic        m1_req, m1_cmd, m2_req, m2_cmd, s_ack;
  logic [31:0] m1_addr, m1_wdata, m2_addr, m2_wdata, s_rdata;
  logic        m1_ack, m2_ack, s_req, s_cmd;
  logic [31:0] m1_rdata, m2_rdata, s_addr, s_wdata;
  typedef struct {
    logic        req, cmd, a1, a2;
    logic [31:0] addr, wdata, r1, r2;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int owner = 0;
  always #5 clk = ~clk;
  mux_masters dut (
    .clk(clk), .rst_n(rst_n), .arb_master_req(grant),
    .master_1_req(m1_req), .master_1_addr(m1_addr), .master_1_cmd(m1_cmd), .master_1_wdata(m1_wdata),
    .master_2_req(m2_req), .master_2_addr(m2_addr), .master_2_cmd(m2_cmd), .master_2_wdata(m2_wdata),
    .slave_ack(s_ack), .slave_rdata(s_rdata),
    .master_1_ack(m1_ack), .master_1_rdata(m1_rdata),
    .master_2_ack(m2_ack), .master_2_rdata(m2_rdata),
    .slave_req(s_req), .slave_addr(s_addr), .slave_cmd(s_cmd), .slave_wdata(s_wdata)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // Drive one cycle, predict the response from the transfer rules, then advance the lock model.
  task automatic cyc(input logic rn, input logic [1:0] g, input logic r1, input logic c1,
                     input logic [31:0] w1, input logic r2, input logic c2, input logic [31:0] w2,
                     input logic ak, input logic [31:0] rd);
    exp_t e;
    int who;
    rst_n = rn; grant = g; s_ack = ak; s_rdata = rd;
    m1_req = r1; m1_cmd = c1; m1_wdata = w1; m1_addr = $urandom;
    m2_req = r2; m2_cmd = c2; m2_wdata = w2; m2_addr = $urandom;
    if (!rn) owner = 0;
    who = owner != 0 ? owner : g[0] ? 1 : g[1] ? 2 : 0;
    e.req   = rn && (who == 1 ? r1 : who == 2 ? r2 : 1'b0);
    e.addr  = who == 1 ? m1_addr : who == 2 ? m2_addr : 32'h0;
    e.cmd   = who == 1 ? c1 : who == 2 ? c2 : 1'b0;
    e.wdata = who == 1 ? w1 : who == 2 ? w2 : 32'h0;
    e.a1    = rn && who == 1 && ak;
    e.a2    = rn && who == 2 && ak;
`ifdef MUX_MASTERS_RDATA_GATE_EN
    e.r1 = who == 1 ? rd : 32'h0;
    e.r2 = who == 2 ? rd : 32'h0;
`else
    e.r1 = rd;
    e.r2 = rd;
`endif
    q.push_back(e);
    if (!rn || ak) owner = 0;
    else if (e.req) owner = who;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("slave_req", {31'b0, s_req}, {31'b0, e.req});
      chk("slave_addr", s_addr, e.addr);
      chk("slave_cmd", {31'b0, s_cmd}, {31'b0, e.cmd});
      chk("slave_wdata", s_wdata, e.wdata);
      chk("master_1_ack", {31'b0, m1_ack}, {31'b0, e.a1});
      chk("master_2_ack", {31'b0, m2_ack}, {31'b0, e.a2});
      chk("master_1_rdata", m1_rdata, e.r1);
      chk("master_2_rdata", m2_rdata, e.r2);
    end
  initial begin
    rst_n = 1'b0; grant = 2'b00; s_ack = 1'b0; s_rdata = '0;
    m1_req = 1'b0; m1_cmd = 1'b0; m1_wdata = '0; m1_addr = '0;
    m2_req = 1'b0; m2_cmd = 1'b0; m2_wdata = '0; m2_addr = '0;
    @(posedge clk);
    #1;
    cyc(0, 2'b01, 1, 0, 32'h1, 0, 0, 32'h2, 0, 32'h0);
    cyc(0, 2'b01, 1, 0, 32'h1, 0, 0, 32'h2, 1, 32'h5);
    cyc(1, 2'b01, 1, 0, 32'h11111111, 0, 0, 32'h0, 1, 32'hFFFFFFFF);
    cyc(1, 2'b10, 1, 0, 32'h0, 1, 1, 32'hFFFFFFFF, 1, 32'h00000000);
    cyc(1, 2'b01, 1, 0, 32'hA, 1, 1, 32'hB, 0, 32'h1);
    cyc(1, 2'b10, 1, 0, 32'hA, 1, 1, 32'hB, 0, 32'h2);
    cyc(1, 2'b10, 1, 0, 32'hA, 1, 1, 32'hB, 0, 32'h3);
    cyc(1, 2'b10, 1, 0, 32'hA, 1, 1, 32'hB, 1, 32'h4);
    cyc(1, 2'b10, 1, 0, 32'hA, 1, 1, 32'hB, 0, 32'h5);
    cyc(1, 2'b10, 0, 0, 32'hA, 0, 1, 32'hB, 1, 32'h6);
    cyc(1, 2'b11, 1, 1, 32'hC, 1, 0, 32'hD, 1, 32'h7);
    cyc(1, 2'b00, 1, 1, 32'hC, 1, 0, 32'hD, 0, 32'h8);
    cyc(1, 2'b00, 1, 1, 32'hC, 1, 0, 32'hD, 1, 32'h9);
    cyc(1, 2'b01, 1, 1, 32'hE, 0, 0, 32'hF, 0, 32'h1);
    cyc(0, 2'b10, 1, 1, 32'hE, 1, 0, 32'hF, 0, 32'h2);
    cyc(1, 2'b10, 1, 1, 32'hE, 1, 0, 32'hF, 0, 32'h3);
    cyc(1, 2'b10, 1, 1, 32'hE, 1, 0, 32'hF, 1, 32'h4);
    for (int i = 0; i < 64; i++)
      cyc(1, (i / 4) % 2 == 0 ? 2'b01 : 2'b10, 1'($urandom), 1'($urandom), $urandom,
          1'($urandom), 1'($urandom), $urandom, 1'((i / 2) % 2), $urandom);
    for (int i = 0; i < 300; i++)
      cyc(($urandom % 16) != 0, 2'($urandom), 1'($urandom), 1'($urandom), $urandom,
          1'($urandom), 1'($urandom), $urandom, ($urandom % 4) == 0, $urandom);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
